// File: rtl/fir_top_level.sv
// fir_top_level: bit-serial in / bit-serial out FIR filter.
// A deserializer collects LSB-first signed samples, a single-MAC engine walks
// a FIR_DEPTH-entry circular history newest-to-oldest, and a serializer returns
// the result LSB-first under sink handshake.
// Optional feature macro: FIR_COEFF_ROM_EN (coefficient ROM table;
// otherwise boxcar average with all taps = 1 and no multiplier).
module fir_top_level #(
  parameter int DATA_WIDTH = 24,
  parameter int FIR_DEPTH  = 256
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_din,
  input  logic i_din_valid,
  input  logic i_ready,
  output logic o_ready,
  output logic o_dout,
  output logic o_dout_valid
);

  localparam int LOG2 = $clog2(FIR_DEPTH);
  localparam int CW   = $clog2(DATA_WIDTH);
`ifdef FIR_COEFF_ROM_EN
  localparam int ACC_W = 2 * DATA_WIDTH + LOG2;
`else
  localparam int ACC_W = DATA_WIDTH + LOG2 + 1;
`endif

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_MAC, S_DONE} state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [DATA_WIDTH-1:0]   r_in_shift;
  logic [CW-1:0]           r_in_cnt;
  logic [DATA_WIDTH-1:0]   fir_din;
  logic [DATA_WIDTH-1:0]   fir_dout;
  logic [LOG2-1:0]         r_wptr;
  logic [LOG2:0]           r_fill;
  logic [LOG2-1:0]         r_tap;
  logic signed [ACC_W-1:0] r_acc;
  logic [DATA_WIDTH-1:0]   r_hist [FIR_DEPTH];
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic [DATA_WIDTH-1:0]   r_out_shift;
  logic [CW-1:0]           r_out_cnt;
  logic                    r_out_valid;

  logic                    w_in_accept;
  logic                    w_in_last;
  logic [DATA_WIDTH-1:0]   w_in_word;
  logic [LOG2-1:0]         w_rd_addr;
  logic [DATA_WIDTH-1:0]   w_sample;
  logic                    w_tap_valid;
  logic signed [ACC_W-1:0] w_term;
  logic [DATA_WIDTH-1:0]   w_result;
  logic                    w_load;

  assign o_ready      = i_en & (r_state == S_IDLE) & i_rst;
  assign o_dout       = r_out_shift[0];
  assign o_dout_valid = r_out_valid;

  assign w_in_accept = i_en & i_din_valid & o_ready;
  assign w_in_last   = w_in_accept & (r_in_cnt == CW'(DATA_WIDTH - 1));
  assign w_in_word   = {i_din, r_in_shift[DATA_WIDTH-1:1]};

  // Tap 0 is the sample just written, taken straight from fir_din; older taps
  // come from the history RAM, read one cycle ahead of their MAC cycle.
  assign w_rd_addr   = r_wptr - r_tap - LOG2'(2);
  assign w_sample    = (r_tap == '0) ? fir_din : r_rdata;
  assign w_tap_valid = ({1'b0, r_tap} < r_fill);
  assign w_load      = i_en & (r_state == S_DONE) & ~r_out_valid;

`ifdef FIR_COEFF_ROM_EN
  logic signed [DATA_WIDTH-1:0]   r_coeff_rom [FIR_DEPTH];
  logic signed [2*DATA_WIDTH-1:0] w_prod;
  logic signed [ACC_W-1:0]        w_shifted;
  localparam logic signed [ACC_W-1:0] C_MAX = ACC_W'({1'b0, {(DATA_WIDTH-1){1'b1}}});
  localparam logic signed [ACC_W-1:0] C_MIN = ~C_MAX;

  // Coefficient table contents, entry 0 applies to the newest sample.
  initial begin
    for (int i = 0; i < FIR_DEPTH; i++)
      r_coeff_rom[i] = DATA_WIDTH'(1) << (DATA_WIDTH - 1 - LOG2);
  end

  assign w_prod    = $signed(w_sample) * r_coeff_rom[r_tap];
  assign w_term    = w_tap_valid ? ACC_W'(w_prod) : '0;
  assign w_shifted = r_acc >>> (DATA_WIDTH - 1);
  assign w_result  = (w_shifted > C_MAX) ? C_MAX[DATA_WIDTH-1:0] :
                     (w_shifted < C_MIN) ? C_MIN[DATA_WIDTH-1:0] :
                     w_shifted[DATA_WIDTH-1:0];
`else
  assign w_term   = w_tap_valid ? ACC_W'($signed(w_sample)) : '0;
  assign w_result = DATA_WIDTH'(r_acc >>> LOG2);
`endif

  // Deserializer: shift bits in LSB-first, hand the finished word to fir_din.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_in_shift <= '0;
      r_in_cnt   <= '0;
      fir_din    <= '0;
    end else if (w_in_accept) begin
      r_in_shift <= w_in_word;
      if (w_in_last) begin
        r_in_cnt <= '0;
        fir_din  <= w_in_word;
      end else begin
        r_in_cnt <= r_in_cnt + CW'(1);
      end
    end
  end

  // Engine state register.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= S_IDLE;
    end else if (i_en) begin
      r_state <= w_state_next;
    end
  end

  // Engine next-state: one write, FIR_DEPTH MAC cycles, then wait for the serializer.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_in_last) w_state_next = S_WRITE;
      S_WRITE: w_state_next = S_MAC;
      S_MAC:   if (r_tap == LOG2'(FIR_DEPTH - 1)) w_state_next = S_DONE;
      S_DONE:  if (!r_out_valid) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Engine datapath: pointer/fill bookkeeping, accumulation and result capture.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_wptr   <= '0;
      r_fill   <= '0;
      r_tap    <= '0;
      r_acc    <= '0;
      fir_dout <= '0;
    end else if (i_en) begin
      case (r_state)
        S_WRITE: begin
          r_wptr <= r_wptr + LOG2'(1);
          if (r_fill != (LOG2+1)'(FIR_DEPTH)) r_fill <= r_fill + (LOG2+1)'(1);
          r_tap  <= '0;
          r_acc  <= '0;
        end
        S_MAC: begin
          r_acc <= r_acc + w_term;
          r_tap <= r_tap + LOG2'(1);
        end
        S_DONE: if (!r_out_valid) fir_dout <= w_result;
        default: ;
      endcase
    end
  end

  // History RAM: written once per sample, read registered; entries never
  // written since reset are masked by the fill count instead of being cleared.
  always_ff @(posedge i_clk) begin
    if (i_en) begin
      if (r_state == S_WRITE) r_hist[r_wptr] <= fir_din;
      r_rdata <= r_hist[w_rd_addr];
    end
  end

  // Serializer: load the result once empty, shift out LSB-first on sink ready.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_out_shift <= '0;
      r_out_cnt   <= '0;
      r_out_valid <= 1'b0;
    end else if (w_load) begin
      r_out_shift <= w_result;
      r_out_cnt   <= '0;
      r_out_valid <= 1'b1;
    end else if (i_en & r_out_valid & i_ready) begin
      r_out_shift <= r_out_shift >> 1;
      if (r_out_cnt == CW'(DATA_WIDTH - 1)) begin
        r_out_cnt   <= '0;
        r_out_valid <= 1'b0;
      end else begin
        r_out_cnt <= r_out_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_fir_top_level.sv
// tb_fir_top_level: randomized scoreboard bench for fir_top_level (boxcar build).
// The reference model keeps the last FIR_DEPTH samples in a queue and averages
// them with floor division; expected words are queued when a sample is sent and
// a monitor pops them as serial output words complete.
module tb_fir_top_level;

  localparam int DW   = 24;
  localparam int FD   = 256;
  localparam int LG   = $clog2(FD);
  localparam int TMO  = 20000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b1;
  logic din = 1'b0;
  logic din_valid = 1'b0;
  logic rdy = 1'b0;
  logic o_ready;
  logic dout;
  logic dout_valid;

  fir_top_level #(.DATA_WIDTH(DW), .FIR_DEPTH(FD)) dut (
    .i_clk       (clk),
    .i_rst       (rst_n),
    .i_en        (en),
    .i_din       (din),
    .i_din_valid (din_valid),
    .i_ready     (rdy),
    .o_ready     (o_ready),
    .o_dout      (dout),
    .o_dout_valid(dout_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0] exp_q[$];
  longint        hist[$];
  int            rdy_mode  = 0;   // 0: ready high, 1: random, 2: held low
  int            last_rise = 0;
  int            last_l    = 0;
  logic [DW-1:0] mon_word;
  int            mon_bits  = 0;
  logic          mon_prev_v = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: floor of the mean of the last FD samples, missing ones are zero.
  function automatic logic [DW-1:0] model_push(input logic [DW-1:0] word);
    longint s;
    longint q;
    hist.push_front(longint'($signed(word)));
    if (hist.size() > FD) void'(hist.pop_back());
    s = 0;
    foreach (hist[i]) s += hist[i];
    q = s >>> LG;
    return q[DW-1:0];
  endfunction

  // Monitor: collect accepted output bits and score each completed word.
  initial begin
    logic [DW-1:0] e;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0:       rdy = 1'b1;
        1:       rdy = 1'($urandom_range(1));
        default: rdy = 1'b0;
      endcase
      #1;
      if (!rst_n) begin
        mon_bits   = 0;
        mon_prev_v = 1'b0;
      end else begin
        if (dout_valid && !mon_prev_v) last_rise = cyc;
        mon_prev_v = dout_valid;
        if (dout_valid && rdy && en) begin
          mon_word[mon_bits] = dout;
          mon_bits++;
          if (mon_bits == DW) begin
            mon_bits = 0;
            if (exp_q.size() == 0) begin
              n_tests++;
              n_fail++;
              $display("FAIL unexpected_word: got 0x%0h, expected no word", mon_word);
            end else begin
              e = exp_q.pop_front();
              check("dout_word", 64'(mon_word), 64'(e));
              check("fir_dout", 64'(dut.fir_dout), 64'(e));
              $display("[TB] word out 0x%06h expected 0x%06h", mon_word, e);
            end
          end
        end
      end
    end
  end

  task automatic send(input logic [DW-1:0] word, input bit gaps, input bit en_rand);
    int n = 0;
    int t = 0;
    logic [DW-1:0] e;
    while (n < DW && t < TMO) begin
      @(negedge clk);
      t++;
      en = en_rand ? ($urandom_range(3) != 0) : 1'b1;
      if (gaps && $urandom_range(2) == 0) begin
        din_valid = 1'b0;
        #1;
      end else begin
        din = word[n];
        din_valid = 1'b1;
        #1;
        if (o_ready) n++;
      end
    end
    if (n < DW) begin
      check("send_timeout", 64'(n), 64'(DW));
      din_valid = 1'b0;
      en = 1'b1;
    end else begin
      @(posedge clk);
      #1;
      last_l = cyc;
      din_valid = 1'b0;
      en = 1'b1;
      check("fir_din", 64'(dut.fir_din), 64'(word));
      e = model_push(word);
      exp_q.push_back(e);
      $display("[TB] word in 0x%06h expect 0x%06h", word, e);
    end
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((exp_q.size() != 0 || dout_valid) && t < 4*TMO) begin
      @(negedge clk);
      #2;
      t++;
    end
    check("drain_in_time", 64'(t < 4*TMO), 64'(1));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    en = 1'b1;
    din_valid = 1'b0;
    #1;
    exp_q.delete();
    hist.delete();
    check("rst_dout_valid", 64'(dout_valid), 64'(0));
    check("rst_o_ready", 64'(o_ready), 64'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic b0;
    int t;
    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_o_ready", 64'(o_ready), 64'(0));
    check("rst_dout_valid", 64'(dout_valid), 64'(0));
    check("rst_dout", 64'(dout), 64'(0));
    check("rst_fir_din", 64'(dut.fir_din), 64'(0));
    check("rst_fir_dout", 64'(dut.fir_dout), 64'(0));
    rst_n = 1'b1;

    // Single small sample and output latency
    rdy_mode = 0;
    send(24'h000100, 1'b0, 1'b0);
    wait_drain();
    check("latency", 64'(last_rise - last_l), 64'(FD + 2));

    // Negative sample floors toward minus infinity
    do_reset();
    send(24'hFFFF00, 1'b0, 1'b0);
    wait_drain();

    // Stalled sink: first word held, second result waits in the engine
    do_reset();
    rdy_mode = 2;
    send(24'($urandom), 1'b0, 1'b0);
    t = 0;
    while (!dout_valid && t < TMO) begin
      @(negedge clk);
      #1;
      t++;
    end
    check("first_valid_seen", 64'(dout_valid), 64'(1));
    b0 = dout;
    send(24'($urandom), 1'b0, 1'b0);
    repeat (FD + 20) @(negedge clk);
    #2;
    check("stall_valid", 64'(dout_valid), 64'(1));
    check("stall_bit0", 64'(dout), 64'(b0));
    check("stall_o_ready", 64'(o_ready), 64'(0));
    rdy_mode = 0;
    wait_drain();

    // Random samples with input gaps, enable drops and random sink ready
    do_reset();
    rdy_mode = 1;
    for (int i = 0; i < 6; i++) send(24'($urandom), 1'b1, 1'b1);
    wait_drain();

    // Reset in the middle of an output transfer, then history must be empty
    rdy_mode = 1;
    send(24'($urandom), 1'b0, 1'b0);
    t = 0;
    while (!dout_valid && t < TMO) begin
      @(negedge clk);
      #1;
      t++;
    end
    repeat (5) @(negedge clk);
    do_reset();
    rdy_mode = 0;
    send(24'h000100, 1'b0, 1'b0);
    wait_drain();

    // Full-scale history, then one zero sample
    do_reset();
    rdy_mode = 0;
    for (int i = 0; i < FD; i++) send(24'h7FFFFF, 1'b0, 1'b0);
    send(24'h000000, 1'b0, 1'b0);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
